// File: rtl/srm_ctrl_pkg.sv
// Shared encodings for the SRM control FSM: opcodes, states, writeback selects, ALU/shift codes.
package srm_ctrl_pkg;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MEM  = 2'b00;

  localparam logic [3:0] VSEL_MDATA = 4'b1000;
  localparam logic [3:0] VSEL_IMM   = 4'b0100;
  localparam logic [3:0] VSEL_C     = 4'b0001;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_GETA, S_GETB, S_EXEC, S_WRC, S_WRIMM,
    S_ADDR, S_LATCH, S_MOVB, S_MEM, S_WRM, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    IC_ILLEGAL, IC_MOVI, IC_MOVR, IC_ADD, IC_CMP, IC_AND, IC_MVN, IC_LDR, IC_STR, IC_HALT
  } iclass_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction
endpackage

// File: rtl/srm_instr_decode.sv
// Combinational IR decode: field extraction, immediate sign extension, instruction class.
module srm_instr_decode
  import srm_ctrl_pkg::*;
(
  input  logic [15:0] i_ir,
  output iclass_t     o_class,
  output logic [2:0]  o_rn,
  output logic [2:0]  o_rd,
  output logic [2:0]  o_rm,
  output logic [1:0]  o_sh,
  output logic [15:0] o_sximm8,
  output logic [15:0] o_sximm5
);
  logic [2:0] w_opc;
  logic [1:0] w_op;

  assign w_opc    = i_ir[15:13];
  assign w_op     = i_ir[12:11];
  assign o_rn     = i_ir[10:8];
  assign o_rd     = i_ir[7:5];
  assign o_sh     = i_ir[4:3];
  assign o_rm     = i_ir[2:0];
  assign o_sximm8 = sext8(i_ir[7:0]);
  assign o_sximm5 = sext5(i_ir[4:0]);

  always_comb begin
    o_class = IC_ILLEGAL;
    case (w_opc)
      OPC_MOV: begin
        if (w_op == OP_MOVI)      o_class = IC_MOVI;
        else if (w_op == OP_MOVR) o_class = IC_MOVR;
      end
      OPC_ALU: begin
        case (w_op)
          OP_ADD:  o_class = IC_ADD;
          OP_CMP:  o_class = IC_CMP;
          OP_AND:  o_class = IC_AND;
          default: o_class = IC_MVN;
        endcase
      end
      OPC_LDR:  if (w_op == OP_MEM) o_class = IC_LDR;
      OPC_STR:  if (w_op == OP_MEM) o_class = IC_STR;
      OPC_HALT: o_class = IC_HALT;
      default:  ;
    endcase
  end
endmodule

// File: rtl/srm_controller.sv
// SRM multi-cycle control FSM. Define SRM_CTRL_MEM_TIMEOUT_EN to abort MEM after MEM_TIMEOUT
// cycles without mem_ack; otherwise MEM waits indefinitely.
module srm_controller
  import srm_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  output logic [3:0]  vsel,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        load_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic        halted,
  output logic        err
);
  state_t      r_state, w_next;
  logic [15:0] r_ir;
  logic        r_err, w_err_set, w_to_fire;
  iclass_t     w_class;
  logic [2:0]  w_rn, w_rd, w_rm;
  logic [1:0]  w_sh;

  srm_instr_decode u_dec (
    .i_ir     (r_ir),
    .o_class  (w_class),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_rm     (w_rm),
    .o_sh     (w_sh),
    .o_sximm8 (sximm8),
    .o_sximm5 (sximm5)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_set;
      if (r_state == S_IDLE && in_valid) r_ir <= instr;
    end
  end

  assign err = r_err;

`ifdef SRM_CTRL_MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Counts MEM cycles already spent; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_to_cnt <= '0;
    else if (r_state != S_MEM)  r_to_cnt <= '0;
    else                        r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_to_fire = (r_state == S_MEM) && !mem_ack && (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));
`else
  logic w_unused_to;
  assign w_unused_to = (MEM_TIMEOUT > 0);
  assign w_to_fire   = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    in_ready  = 1'b0;
    vsel      = VSEL_C;
    readnum   = 3'd0;
    writenum  = 3'd0;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    shift     = SH_NONE;
    ALUop     = ALU_ADD;
    loadc     = 1'b0;
    loads     = 1'b0;
    load_addr = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    halted    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_class)
          IC_MOVI:                        w_next = S_WRIMM;
          IC_MOVR, IC_MVN:                w_next = S_GETB;
          IC_ADD, IC_AND, IC_CMP,
          IC_LDR, IC_STR:                 w_next = S_GETA;
          IC_HALT:                        w_next = S_HALT;
          default: begin
            w_next    = S_IDLE;
            w_err_set = 1'b1;
          end
        endcase
      end
      S_GETA: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = (w_class == IC_LDR || w_class == IC_STR) ? S_ADDR : S_GETB;
      end
      S_GETB: begin
        // STR reuses GETB to fetch the data register into B.
        readnum = (w_class == IC_STR) ? w_rd : w_rm;
        loadb   = 1'b1;
        w_next  = (w_class == IC_STR) ? S_MOVB : S_EXEC;
      end
      S_EXEC: begin
        asel  = (w_class == IC_MOVR || w_class == IC_MVN);
        shift = w_sh;
        case (w_class)
          IC_AND:  ALUop = ALU_AND;
          IC_CMP:  ALUop = ALU_SUB;
          IC_MVN:  ALUop = ALU_NOTB;
          default: ALUop = ALU_ADD;
        endcase
        loadc  = (w_class != IC_CMP);
        loads  = (w_class == IC_CMP);
        w_next = (w_class == IC_CMP) ? S_IDLE : S_WRC;
      end
      S_WRC: begin
        vsel     = VSEL_C;
        writenum = w_rd;
        write    = 1'b1;
        w_next   = S_IDLE;
      end
      S_WRIMM: begin
        vsel     = VSEL_IMM;
        writenum = w_rn;
        write    = 1'b1;
        w_next   = S_IDLE;
      end
      S_ADDR: begin
        bsel   = 1'b1;
        loadc  = 1'b1;
        w_next = S_LATCH;
      end
      S_LATCH: begin
        load_addr = 1'b1;
        w_next    = (w_class == IC_LDR) ? S_MEM : S_GETB;
      end
      S_MOVB: begin
        asel   = 1'b1;
        loadc  = 1'b1;
        w_next = S_MEM;
      end
      S_MEM: begin
        mem_rd = (w_class == IC_LDR);
        mem_wr = (w_class == IC_STR);
        if (mem_ack) begin
          w_next = (w_class == IC_LDR) ? S_WRM : S_IDLE;
        end else if (w_to_fire) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_WRM: begin
        vsel     = VSEL_MDATA;
        writenum = w_rd;
        write    = 1'b1;
        w_next   = S_IDLE;
      end
      S_HALT: halted = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_srm_controller.sv
// Self-checking bench for srm_controller: directed scenarios plus random instructions
// compared against a transaction-level model (latency, reads, writes, memory activity).
module tb_srm_controller;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        mem_ack = 1'b0;
  logic        in_ready, write, loada, loadb, asel, bsel, loadc, loads;
  logic        load_addr, mem_rd, mem_wr, halted, err;
  logic [3:0]  vsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int checks = 0;
  int fails  = 0;

  srm_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .vsel(vsel), .readnum(readnum), .writenum(writenum), .write(write), .loada(loada),
    .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop), .loadc(loadc),
    .loads(loads), .sximm8(sximm8), .sximm5(sximm5), .load_addr(load_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_ack(mem_ack), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // One instruction's externally visible behaviour, summarised.
  typedef struct packed {
    int lat;   int wr_n;  int wrnum; int vsel;
    int la_n;  int la_rn; int lb_n;  int lb_rn;
    int lc_n;  int ls_n;  int alu;   int sh;
    int asel;  int bsel;  int ldaddr_n;
    int rd_n;  int wrm_n; int err_n;
  } txn_t;

  txn_t obs;
  int   obs_wr_cyc;
  int   obs_both;

  function automatic txn_t model(input logic [15:0] ins, input int w);
    txn_t e;
    int opc, op, rn, rd, sh, rm;
    opc = int'(ins[15:13]); op = int'(ins[12:11]); rn = int'(ins[10:8]);
    rd  = int'(ins[7:5]);   sh = int'(ins[4:3]);   rm = int'(ins[2:0]);
    e = '0;
    if (opc == 6 && op == 2) begin
      e.lat = 3; e.wr_n = 1; e.wrnum = rn; e.vsel = 4;
    end else if ((opc == 6 && op == 0) || (opc == 5 && op == 3)) begin
      e.lat = 5; e.lb_n = 1; e.lb_rn = rm; e.lc_n = 1; e.sh = sh; e.asel = 1;
      e.alu = (opc == 5) ? 3 : 0; e.wr_n = 1; e.wrnum = rd; e.vsel = 1;
    end else if (opc == 5) begin
      e.la_n = 1; e.la_rn = rn; e.lb_n = 1; e.lb_rn = rm; e.alu = op; e.sh = sh;
      if (op == 1) begin
        e.lat = 5; e.ls_n = 1;
      end else begin
        e.lat = 6; e.lc_n = 1; e.wr_n = 1; e.wrnum = rd; e.vsel = 1;
      end
    end else if (opc == 3 && op == 0) begin
      e.lat = 7 + w; e.la_n = 1; e.la_rn = rn; e.lc_n = 1; e.bsel = 1; e.ldaddr_n = 1;
      e.rd_n = w + 1; e.wr_n = 1; e.wrnum = rd; e.vsel = 8;
    end else if (opc == 4 && op == 0) begin
      e.lat = 8 + w; e.la_n = 1; e.la_rn = rn; e.lb_n = 1; e.lb_rn = rd; e.lc_n = 2;
      e.bsel = 1; e.ldaddr_n = 1; e.wrm_n = w + 1;
    end else begin
      e.lat = 2; e.err_n = 1;
    end
    return e;
  endfunction

  // Offers one instruction and records what happens until in_ready returns.
  // mem_ack is raised during the (w+1)-th MEM cycle; w<0 means never.
  task automatic run_instr(input logic [15:0] ins, input int w);
    int  memc;
    bit  seen_ex;
    obs = '0; obs_wr_cyc = 0; obs_both = 0; memc = 0; seen_ex = 0;
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1; instr = ins;
    @(posedge clk);
    #1 in_valid = 1'b0; instr = 16'($urandom);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (write) begin obs.wr_n++; obs_wr_cyc = c; obs.wrnum = int'(writenum); obs.vsel = int'(vsel); end
      if (loada) begin obs.la_n++; obs.la_rn = int'(readnum); end
      if (loadb) begin obs.lb_n++; obs.lb_rn = int'(readnum); end
      if (loadc) obs.lc_n++;
      if (loads) obs.ls_n++;
      if ((loadc || loads) && !seen_ex) begin
        seen_ex = 1; obs.alu = int'(ALUop); obs.sh = int'(shift);
        obs.asel = int'(asel); obs.bsel = int'(bsel);
      end
      if (load_addr) obs.ldaddr_n++;
      if (mem_rd) obs.rd_n++;
      if (mem_wr) obs.wrm_n++;
      if (mem_rd && mem_wr) obs_both++;
      if (mem_rd || mem_wr) begin memc++; if (memc == w + 1) mem_ack = 1'b1; end
      if (err) obs.err_n++;
      if (in_ready) begin obs.lat = c; break; end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({write, loada, loadb, loadc, loads, asel, bsel, load_addr, mem_rd, mem_wr, halted, err,
         shift, ALUop, readnum, writenum} !== '0 || vsel !== 4'b0001) begin
      fails++;
      $display("FAIL reset_outputs vsel=%b shift=%b ALUop=%b rn=%0d wn=%0d wr=%b halted=%b err=%b required vsel=0001 rest 0",
               vsel, shift, ALUop, readnum, writenum, write, halted, err);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_mov_imm();
    run_instr(16'hD107, 0);
    checks++;
    // Accept cycle is cycle 0; WRIMM is the 3rd cycle counting the accept cycle.
    if (obs_wr_cyc !== 2 || obs.wr_n !== 1 || obs.wrnum !== 1 || obs.vsel !== 4) begin
      fails++;
      $display("FAIL movi_write cyc=%0d n=%0d wn=%0d vsel=%0d required cyc=2 n=1 wn=1 vsel=4",
               obs_wr_cyc, obs.wr_n, obs.wrnum, obs.vsel);
    end
    checks++;
    if (obs.lat !== 3) begin fails++; $display("FAIL movi_latency got=%0d required=3", obs.lat); end
    checks++;
    if (sximm8 !== 16'h0007) begin fails++; $display("FAIL movi_sximm8 got=%h required=0007", sximm8); end
  endtask

  task automatic test_add();
    run_instr(16'hA148, 0);
    checks++;
    if (obs.la_n !== 1 || obs.la_rn !== 1 || obs.lb_n !== 1 || obs.lb_rn !== 0) begin
      fails++;
      $display("FAIL add_reads la=%0d/%0d lb=%0d/%0d required la=1/1 lb=1/0", obs.la_n, obs.la_rn, obs.lb_n, obs.lb_rn);
    end
    checks++;
    if (obs.sh !== 1 || obs.alu !== 0 || obs.lc_n !== 1 || obs.asel !== 0) begin
      fails++;
      $display("FAIL add_exec sh=%0d alu=%0d lc=%0d asel=%0d required 1 0 1 0", obs.sh, obs.alu, obs.lc_n, obs.asel);
    end
    checks++;
    if (obs.wr_n !== 1 || obs.wrnum !== 2 || obs.vsel !== 1 || obs.lat !== 6) begin
      fails++;
      $display("FAIL add_write n=%0d wn=%0d vsel=%0d lat=%0d required 1 2 1 6", obs.wr_n, obs.wrnum, obs.vsel, obs.lat);
    end
  endtask

  task automatic test_cmp();
    run_instr(16'hA948, 0);
    checks++;
    if (obs.ls_n !== 1 || obs.alu !== 1 || obs.lc_n !== 0) begin
      fails++;
      $display("FAIL cmp_status loads=%0d alu=%0d loadc=%0d required 1 1 0", obs.ls_n, obs.alu, obs.lc_n);
    end
    checks++;
    if (obs.wr_n !== 0 || obs.lat !== 5) begin
      fails++; $display("FAIL cmp_nowrite writes=%0d lat=%0d required 0 5", obs.wr_n, obs.lat);
    end
  endtask

  task automatic test_ldr();
    run_instr(16'h617E, 2);
    checks++;
    if (sximm5 !== 16'hFFFE || obs.bsel !== 1 || obs.ldaddr_n !== 1) begin
      fails++;
      $display("FAIL ldr_addr sximm5=%h bsel=%0d load_addr=%0d required FFFE 1 1", sximm5, obs.bsel, obs.ldaddr_n);
    end
    checks++;
    if (obs.rd_n !== 3 || obs.wrm_n !== 0 || obs_both !== 0) begin
      fails++; $display("FAIL ldr_mem rd=%0d wr=%0d both=%0d required 3 0 0", obs.rd_n, obs.wrm_n, obs_both);
    end
    checks++;
    if (obs.wr_n !== 1 || obs.vsel !== 8 || obs.wrnum !== 3 || obs.lat !== 9) begin
      fails++;
      $display("FAIL ldr_write n=%0d vsel=%0d wn=%0d lat=%0d required 1 8 3 9", obs.wr_n, obs.vsel, obs.wrnum, obs.lat);
    end
  endtask

  task automatic test_random();
    txn_t        e;
    logic [15:0] ins;
    int          w, v8, v5;
    for (int n = 0; n < 40; n++) begin
      ins = 16'($urandom);
      if (ins[15:13] == 3'b111) ins[15:13] = 3'($urandom_range(0, 6));
      if (n % 4 == 0) ins[12:11] = 2'b00;  // bias toward legal LDR/STR/MOV forms
      w = int'($urandom_range(0, 3));
      e = model(ins, w);
      run_instr(ins, w);
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL rand_txn ins=%h w=%0d got=%h required=%h", ins, w, obs, e);
      end
      v8 = int'(ins[7:0]); if (v8 > 127) v8 -= 256;
      v5 = int'(ins[4:0]); if (v5 > 15) v5 -= 32;
      checks++;
      if (sximm8 !== 16'(v8) || sximm5 !== 16'(v5) || obs_both !== 0) begin
        fails++;
        $display("FAIL rand_imm ins=%h sximm8=%h sximm5=%h both=%0d required %h %h 0", ins, sximm8, sximm5, obs_both, 16'(v8), 16'(v5));
      end
    end
  endtask

  task automatic test_mem_timeout();
`ifdef SRM_CTRL_MEM_TIMEOUT_EN
    run_instr(16'h617E, -1);
    checks++;
    if (obs.rd_n !== 4 || obs.err_n !== 1 || obs.wr_n !== 0 || obs.lat !== 9) begin
      fails++;
      $display("FAIL mem_timeout rd=%0d err=%0d wr=%0d lat=%0d required 4 1 0 9", obs.rd_n, obs.err_n, obs.wr_n, obs.lat);
    end
`else
    run_instr(16'h617E, 20);
    checks++;
    if (obs.rd_n !== 21 || obs.err_n !== 0 || obs.wr_n !== 1 || obs.lat !== 27) begin
      fails++;
      $display("FAIL mem_wait rd=%0d err=%0d wr=%0d lat=%0d required 21 0 1 27", obs.rd_n, obs.err_n, obs.wr_n, obs.lat);
    end
`endif
  endtask

  task automatic test_reset_in_mem();
    bit seen;
    seen = 0;
    @(negedge clk);
    in_valid = 1'b1; instr = 16'h8120;  // STR R1,[R1,#0]
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_wr) seen = 1;
    end
    checks++;
    if (!seen) begin fails++; $display("FAIL str_reach_mem mem_wr never seen required 1"); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || write !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_mem mem_wr=%b mem_rd=%b write=%b in_ready=%b required 0 0 0 1", mem_wr, mem_rd, write, in_ready);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || write !== 1'b0) begin
      fails++; $display("FAIL reset_release in_ready=%b write=%b required 1 0", in_ready, write);
    end
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    @(negedge clk);
    in_valid = 1'b1; instr = 16'hE000;
    @(posedge clk);
    #1 instr = 16'hD107;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      instr = 16'($urandom);
      if (halted !== 1'b1 || in_ready !== 1'b0 || write !== 1'b0 || err !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      fails++; $display("FAIL halt_hold bad_cycles=%0d halted=%b in_ready=%b required 0 1 0", bad, halted, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_ldr();
    test_random();
    test_mem_timeout();
    test_reset_in_mem();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
